// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmitter state encoding and line levels,
// kept here so a receiver can use the same names.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_tick.sv
// Tick-driven UART transmitter: one bit per tick pulse, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state, state_n;
  logic                 tx_n, busy_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CNT_W-1:0]     bitcnt, bitcnt_n;
  logic                 stopcnt, stopcnt_n;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
      shift   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      busy    <= busy_n;
      shift   <= shift_n;
      bitcnt  <= bitcnt_n;
      stopcnt <= stopcnt_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx;
    busy_n    = busy;
    shift_n   = shift;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
`ifdef UART_TX_PARITY_EN
    par_n     = par;
`endif
    case (state)
      // tick in the accept cycle is deliberately ignored
      IDLE: begin
        if (valid) begin
          shift_n = data;
          busy_n  = 1'b1;
          state_n = SYNC;
`ifdef UART_TX_PARITY_EN
          par_n   = ^data;
`endif
        end
      end
      // wait for a tick so the start bit lasts a full tick period
      SYNC: begin
        if (tick) begin
          tx_n    = UART_START_LEVEL;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          tx_n     = shift[0];
          shift_n  = shift >> 1;
          bitcnt_n = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_n      = par;
            state_n   = PARITY;
`else
            tx_n      = UART_IDLE_LEVEL;
            stopcnt_n = 1'b0;
            state_n   = STOP;
`endif
          end else begin
            tx_n     = shift[0];
            shift_n  = shift >> 1;
            bitcnt_n = bitcnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (tick) begin
          tx_n      = UART_IDLE_LEVEL;
          stopcnt_n = 1'b0;
          state_n   = STOP;
        end
`else
        state_n = IDLE;
`endif
      end
      STOP: begin
        tx_n = UART_IDLE_LEVEL;
        if (tick) begin
          if (stopcnt == LAST_STOP) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            stopcnt_n = stopcnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Scoreboard bench for uart_tx_tick: accepted bytes become expected line
// sequences; a monitor compares the line at every bit-period boundary.
module tb_uart_tx_tick;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FLEN = 1 + DATA_BITS + PBITS + STOP_BITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, tx, busy;

  uart_tx_tick #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .data(data),
    .valid(valid), .ready(ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line levels of one frame in transmission order, bit 0 first.
  function automatic logic [15:0] frame_bits(input logic [7:0] b);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[1+DATA_BITS] = ^b;
`endif
    return f;
  endfunction

  logic [7:0]  exp_q[$];
  int          acc_count = 0;
  logic        acc_flag  = 1'b0;
  int          phase     = 0;  // 0 idle, 1 awaiting start, 2 in frame, 3 awaiting end tick
  logic [15:0] cur       = '1;
  int          idx       = 0;
  logic        tx_prev   = 1'b1;
  logic        tick_q    = 1'b0;
  int          mode      = 0;

  always @(posedge clk) tick_q <= tick;

  // input-side monitor: every handshake becomes an expected frame
  always @(posedge clk) begin
    if (!rst && valid && ready) begin
      total++;
      if (phase != 0 || exp_q.size() != 0) begin
        bad++;
        $display("FAIL accept_while_busy: phase=%0d pending=%0d expected idle", phase, exp_q.size());
      end
      exp_q.push_back(data);
      acc_count++;
      acc_flag = 1'b1;
    end
  end

  // line-side monitor
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      exp_q.delete();
      acc_flag = 1'b0;
    end else begin
      if (acc_flag) begin
        acc_flag = 1'b0;
        check("accept_tx_high", tx, 1);
        phase = 1;
      end else if (!tick_q) begin
        check("hold_tx", tx, tx_prev);
      end else begin
        case (phase)
          0: check("idle_tx", tx, 1);
          1: begin
            cur = frame_bits(exp_q.pop_front());
            check("start_bit", tx, cur[0]);
            idx   = 1;
            phase = 2;
          end
          2: begin
            check($sformatf("frame_bit%0d", idx), tx, cur[idx]);
            idx++;
            if (idx == FLEN) phase = 3;
          end
          default: begin
            check("end_tx", tx, 1);
            phase = 0;
          end
        endcase
      end
      check("busy", busy, (phase != 0));
      check("ready", ready, (phase == 0));
    end
    tx_prev = tx;
  end

  // tick source: every 4 clk, tied high, or random
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      case (mode)
        0:       tick = (cnt % 4 == 0);
        1:       tick = 1'b1;
        default: tick = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  task automatic send(input logic [7:0] b, input bit keep);
    int n, t;
    n     = acc_count;
    t     = 0;
    data  = b;
    valid = 1'b1;
    while (acc_count == n && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (acc_count == n) check("send_timeout", 0, 1);
    if (!keep) valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((phase != 0 || exp_q.size() != 0 || acc_flag) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) check("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    mode = 0;
    send(8'hA5, 0);
    wait_done();

    // back-to-back: valid still high when ready rises
    send(8'h00, 1);
    send(8'hFF, 0);
    wait_done();

    // valid held with scrambled data while busy
    send(8'h5A, 1);
    n = acc_count;
    for (int t = 0; t < 2000 && acc_count == n; t++) begin
      data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    wait_done();

    mode = 1;
    send(8'h3C, 0);
    wait_done();

    mode = 0;
    send(8'h07, 0);
    send(8'h03, 0);
    wait_done();

    mode = 2;
    for (int i = 0; i < 20; i++) begin
      mode = int'($urandom_range(0, 2));
      send(8'($urandom), 0);
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    wait_done();

    // reset in the middle of an all-zero data field
    mode = 0;
    send(8'h00, 0);
    repeat (16) @(posedge clk);
    #1;
    check("pre_reset_tx", tx, 0);
    rst = 1'b1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    send(8'h96, 0);
    wait_done();

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
Tick-driven UART transmitter. Consumes the one-cycle enable pulse from the upstream clock-divider stage, one pulse per bit period. Serialises 8N1 frames (optionally 8E1) onto a single TX line. Sits between the CPU's memory-mapped I/O register and the board TX pin; the core clock is never gated, and all timing comes from `tick`.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first.
- STOP_BITS, 1: stop-bit periods per frame (1 or 2).

Ports:
- clk  input  1  core clock; all logic is on posedge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle bit-period strobe from the upstream divider.
- data  input  DATA_BITS  byte to send; sampled on accept.
- valid  input  1  producer has a byte.
- ready  output  1  block can accept; high only in IDLE.
- tx  output  1  serial line, idle-high, registered.
- busy  output  1  frame in progress (state != IDLE), registered.

Behaviour:
- Reset (async, immediate): state=IDLE, tx=1, busy=0, shift register=0, bit counter=0. Reset during a frame aborts it; tx returns high at once and the byte is lost.
- ready is combinational: ready = (state==IDLE).
- Accept: valid && ready on a posedge. data is latched into the shift register, state goes to SYNC, busy=1. data and valid are don't-care afterwards.
- The tick value in the accept cycle is ignored.
- SYNC: tx stays 1. On the next tick, tx<=0 and state goes to START. This aligns the start bit to a full tick period.
- START: on tick, tx<=shift[0], shift>>=1, bitcnt<=0, state goes to DATA.
- DATA: on tick, if bitcnt==DATA_BITS-1 go to the next phase; otherwise tx<=shift[0], shift>>=1, bitcnt++.
  - Next phase without parity: tx<=1, stopcnt<=0, state goes to STOP.
  - Next phase with parity: see Optional Feature.
- STOP: tx=1. On tick, if stopcnt==STOP_BITS-1, state goes to IDLE and busy<=0; otherwise stopcnt++.
- Outside SYNC/START/DATA/STOP transitions, tick has no effect. Between ticks every register holds.
- Latency:
  - Accept to the tx falling edge is the first tick after accept, plus 1 clk (register).
  - Each bit lasts exactly one tick period.
  - Frame = 1 start + DATA_BITS + [parity] + STOP_BITS tick periods.
- Back-to-back: ready rises the cycle after the final stop tick. A byte accepted then goes through SYNC again, so the minimum gap is ≥1 full tick period of extra idle-high.
- tick held high continuously is legal: one bit per clk.
- bitcnt width is $clog2(DATA_BITS); stopcnt width is 1 bit.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - On accept, an even-parity bit p = ^data is latched.
  - After the last data bit, on tick: tx<=p, state goes to PARITY.
  - PARITY: on tick, tx<=1, state goes to STOP.
  - Frame becomes 8E1.
- Undefined: the PARITY state, the p register and its logic are absent; the frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, SYNC, START, DATA, PARITY, STOP} as a 3-bit typedef tx_state_t;
  - constants UART_IDLE_LEVEL=1'b1 and UART_START_LEVEL=1'b0.
  - A future uart_rx reuses the package.
- No sub-module: the shift register, counters and FSM stay in one module. The tick source stays external.

Test Plan:
- Reset → tx=1, busy=0, ready=1. Assert rst mid-DATA → tx=1 within the same cycle, state IDLE, no further toggles.
- tick every 4 clk, send 0xA5 → after SYNC, tx per tick = 0, 1,0,1,0,0,1,0,1, 1. busy high for 40+SYNC clks.
- Send 0x00, then assert valid again in the cycle ready rises with 0xFF → second frame accepted. Line stays idle-high ≥1 tick period between the stop bit and the next start bit.
- valid held high while busy with changing data → no accept until IDLE. Transmitted bits match the originally latched byte.
- tick tied high → 0x3C is transmitted 1 bit/clk: 0,0,0,1,1,1,1,0,0,1.
- With UART_TX_PARITY_EN: send 0x07 → parity bit 1 precedes the stop. Send 0x03 → parity bit 0. Frame is 11 ticks.
